spi_bus_arbiter: RTL and testbench

- Shares one downstream SPI slave bus between two SPI masters: A (Raspberry Pi) and B (auxiliary MCU header).
- Sits in the CPLD in place of a straight SPI passthrough.
- Grants the bus per transaction, using each master's NSS as its request.
- Inserts a guard gap between owners and, optionally, force-releases a master that holds NSS too long.

---
 rtl/spi_bus_arbiter_if.sv | 58 +++++
 rtl/spi_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Signal bundle for the two upstream SPI masters and the shared slave bus.
// The master modport is the arbiter's view; slave is the board-side view.
interface spi_bus_arbiter_if;
  logic A_SPI_CLK_IN;
  logic A_SPI_MOSI_IN;
  logic A_SPI_NSS_IN;
  logic A_SPI_MISO_OUT;
  logic A_GNT;
  logic B_SPI_CLK_IN;
  logic B_SPI_MOSI_IN;
  logic B_SPI_NSS_IN;
  logic B_SPI_MISO_OUT;
  logic B_GNT;
  logic SPI_CLK_OUT;
  logic SPI_MOSI_OUT;
  logic SPI_NSS_OUT;
  logic SPI_MISO_IN;
  logic BUSY;
  logic TIMEOUT_FLAG;

  modport master (
    input  A_SPI_CLK_IN,
    input  A_SPI_MOSI_IN,
    input  A_SPI_NSS_IN,
    output A_SPI_MISO_OUT,
    output A_GNT,
    input  B_SPI_CLK_IN,
    input  B_SPI_MOSI_IN,
    input  B_SPI_NSS_IN,
    output B_SPI_MISO_OUT,
    output B_GNT,
    output SPI_CLK_OUT,
    output SPI_MOSI_OUT,
    output SPI_NSS_OUT,
    input  SPI_MISO_IN,
    output BUSY,
    output TIMEOUT_FLAG
  );

  modport slave (
    output A_SPI_CLK_IN,
    output A_SPI_MOSI_IN,
    output A_SPI_NSS_IN,
    input  A_SPI_MISO_OUT,
    input  A_GNT,
    output B_SPI_CLK_IN,
    output B_SPI_MOSI_IN,
    output B_SPI_NSS_IN,
    input  B_SPI_MISO_OUT,
    input  B_GNT,
    input  SPI_CLK_OUT,
    input  SPI_MOSI_OUT,
    input  SPI_NSS_OUT,
    output SPI_MISO_IN,
    input  BUSY,
    input  TIMEOUT_FLAG
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Per-transaction arbiter sharing one SPI slave bus between masters A and B.
// Define SPI_ARB_TIMEOUT_EN to enable forced release of long grants.
module spi_bus_arbiter #(
  parameter int SYNC_STAGES    = 2,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit CPOL           = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  spi_bus_arbiter_if.master bus
);

  localparam int GW =
    (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LOAD =
    GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT_A,
    GNT_B,
    GUARD
  } state_e;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (GUARD_CYCLES < 1) begin : g_bad_guard
    $error("GUARD_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_a_q;
  logic [SYNC_STAGES-1:0] sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q;
  logic [SYNC_STAGES-1:0] sync_b_d;
  logic                   req_a;
  logic                   req_b;

  state_e                 state_q;
  state_e                 state_d;
  state_e                 idle_next;
  logic [GW-1:0]          guard_q;
  logic [GW-1:0]          guard_d;
  logic                   last_b_q;
  logic                   last_b_d;
  logic                   gnt_a_q;
  logic                   gnt_a_d;
  logic                   gnt_b_q;
  logic                   gnt_b_d;
  logic                   busy_q;
  logic                   busy_d;
  logic                   timeout_ev;
  logic                   to_hit;
  logic                   lock_a;
  logic                   lock_b;
  logic                   eff_a;
  logic                   eff_b;

  // Shift inverted NSS into the request synchronizers.
  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], ~bus.A_SPI_NSS_IN};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], ~bus.B_SPI_NSS_IN};
  end

  // Synchronizer flops; reset means "not requesting".
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
    end
  end

  assign req_a = sync_a_q[SYNC_STAGES-1];
  assign req_b = sync_b_q[SYNC_STAGES-1];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] gcnt_q;
  logic [15:0] gcnt_d;
  logic        lock_a_q;
  logic        lock_a_d;
  logic        lock_b_q;
  logic        lock_b_d;
  logic        to_flag_q;
  logic        to_flag_d;

  assign to_hit = (gcnt_q == TO_LAST);
  assign lock_a = lock_a_q;
  assign lock_b = lock_b_q;
  assign bus.TIMEOUT_FLAG = to_flag_q;

  // Grant-age counter, sticky flag and per-master lockout.
  always_comb begin
    gcnt_d    = gcnt_q;
    lock_a_d  = lock_a_q;
    lock_b_d  = lock_b_q;
    to_flag_d = to_flag_q | timeout_ev;
    if (state_d != state_q) begin
      gcnt_d = '0;
    end else if (state_q == GNT_A || state_q == GNT_B) begin
      gcnt_d = gcnt_q + 16'd1;
    end
    if (!req_a) begin
      lock_a_d = 1'b0;
    end
    if (!req_b) begin
      lock_b_d = 1'b0;
    end
    if (timeout_ev && state_q == GNT_A) begin
      lock_a_d = 1'b1;
    end
    if (timeout_ev && state_q == GNT_B) begin
      lock_b_d = 1'b1;
    end
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gcnt_q    <= '0;
      lock_a_q  <= 1'b0;
      lock_b_q  <= 1'b0;
      to_flag_q <= 1'b0;
    end else begin
      gcnt_q    <= gcnt_d;
      lock_a_q  <= lock_a_d;
      lock_b_q  <= lock_b_d;
      to_flag_q <= to_flag_d;
    end
  end
`else
  logic unused_timeout;

  assign to_hit = 1'b0;
  assign lock_a = 1'b0;
  assign lock_b = 1'b0;
  assign bus.TIMEOUT_FLAG = 1'b0;
  assign unused_timeout =
    timeout_ev ^ (TIMEOUT_CYCLES != 0);
`endif

  assign eff_a = req_a & ~lock_a;
  assign eff_b = req_b & ~lock_b;

  // Idle arbitration: sole requester wins, ties alternate.
  always_comb begin
    idle_next = IDLE;
    if (eff_a && eff_b) begin
      idle_next = last_b_q ? GNT_A : GNT_B;
    end else if (eff_a) begin
      idle_next = GNT_A;
    end else if (eff_b) begin
      idle_next = GNT_B;
    end
  end

  // Next state, guard countdown and registered output values.
  always_comb begin
    state_d    = state_q;
    guard_d    = guard_q;
    timeout_ev = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = idle_next;
      end
      GNT_A: begin
        if (!req_a) begin
          state_d = GUARD;
          guard_d = GUARD_LOAD;
        end else if (to_hit) begin
          state_d    = GUARD;
          guard_d    = GUARD_LOAD;
          timeout_ev = 1'b1;
        end
      end
      GNT_B: begin
        if (!req_b) begin
          state_d = GUARD;
          guard_d = GUARD_LOAD;
        end else if (to_hit) begin
          state_d    = GUARD;
          guard_d    = GUARD_LOAD;
          timeout_ev = 1'b1;
        end
      end
      GUARD: begin
        if (guard_q == '0) begin
          state_d = idle_next;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    last_b_d = last_b_q;
    if (state_d == GNT_A && state_q != GNT_A) begin
      last_b_d = 1'b0;
    end
    if (state_d == GNT_B && state_q != GNT_B) begin
      last_b_d = 1'b1;
    end

    gnt_a_d = (state_d == GNT_A);
    gnt_b_d = (state_d == GNT_B);
    busy_d  = (state_d != IDLE);
  end

  // Arbiter FSM and its registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      guard_q  <= '0;
      last_b_q <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      last_b_q <= last_b_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.A_GNT = gnt_a_q;
  assign bus.B_GNT = gnt_b_q;
  assign bus.BUSY  = busy_q;

  // Bus steering by registered owner; parked bus when unowned.
  always_comb begin
    bus.SPI_NSS_OUT    = 1'b1;
    bus.SPI_CLK_OUT    = CPOL;
    bus.SPI_MOSI_OUT   = 1'b0;
    bus.A_SPI_MISO_OUT = 1'b0;
    bus.B_SPI_MISO_OUT = 1'b0;
    unique case (state_q)
      GNT_A: begin
        bus.SPI_NSS_OUT    = bus.A_SPI_NSS_IN;
        bus.SPI_CLK_OUT    = bus.A_SPI_CLK_IN;
        bus.SPI_MOSI_OUT   = bus.A_SPI_MOSI_IN;
        bus.A_SPI_MISO_OUT = bus.SPI_MISO_IN;
      end
      GNT_B: begin
        bus.SPI_NSS_OUT    = bus.B_SPI_NSS_IN;
        bus.SPI_CLK_OUT    = bus.B_SPI_CLK_IN;
        bus.SPI_MOSI_OUT   = bus.B_SPI_MOSI_IN;
        bus.B_SPI_MISO_OUT = bus.SPI_MISO_IN;
      end
      default: begin
      end
    endcase
  end

  a_one_owner: assert property (
    @(posedge CLK) disable iff (RST)
    !(gnt_a_q && gnt_b_q));

  a_gnt_a_state: assert property (
    @(posedge CLK) disable iff (RST)
    gnt_a_q == (state_q == GNT_A));

  a_gnt_b_state: assert property (
    @(posedge CLK) disable iff (RST)
    gnt_b_q == (state_q == GNT_B));

  a_parked_nss: assert property (
    @(posedge CLK) disable iff (RST)
    (!gnt_a_q && !gnt_b_q) |-> bus.SPI_NSS_OUT);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter.
// Slave-side bytes are checked against a queue of expected MOSI bytes.
module tb_spi_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  spi_bus_arbiter_if bus();

  spi_bus_arbiter #(
    .SYNC_STAGES   (2),
    .GUARD_CYCLES  (4),
    .TIMEOUT_CYCLES(100),
    .CPOL          (1'b0)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] slv_exp_q[$];
  logic [7:0] slv_sr = 8'h00;
  int         slv_bits = 0;

  // Slave model: sample MOSI on SCK rise while selected.
  always @(posedge bus.SPI_CLK_OUT or posedge bus.SPI_NSS_OUT) begin
    if (bus.SPI_NSS_OUT === 1'b1) begin
      slv_bits = 0;
    end else begin
      slv_sr = {slv_sr[6:0], bus.SPI_MOSI_OUT};
      slv_bits++;
      if (slv_bits == 8) begin
        logic [7:0] exp_b;
        slv_bits = 0;
        checks++;
        if (slv_exp_q.size() == 0) begin
          errors++;
          $display("FAIL slave_rx: got %02h, no byte expected", slv_sr);
        end else begin
          exp_b = slv_exp_q.pop_front();
          if (slv_sr !== exp_b) begin
            errors++;
            $display("FAIL slave_rx: got %02h, want %02h", slv_sr, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_nss(input bit is_b, input logic v);
    if (is_b) bus.B_SPI_NSS_IN = v;
    else bus.A_SPI_NSS_IN = v;
  endtask

  task automatic set_sck(input bit is_b, input logic v);
    if (is_b) bus.B_SPI_CLK_IN = v;
    else bus.A_SPI_CLK_IN = v;
  endtask

  task automatic set_mosi(input bit is_b, input logic v);
    if (is_b) bus.B_SPI_MOSI_IN = v;
    else bus.A_SPI_MOSI_IN = v;
  endtask

  task automatic wait_gnt(input bit is_b, input int lim,
                          output int cyc, output bit got);
    cyc = 0;
    got = 0;
    while (cyc < lim) begin
      tick(1);
      cyc++;
      if ((is_b ? bus.B_GNT : bus.A_GNT) === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      tick(1);
      if (bus.BUSY === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  // One byte, mode 0, SCK half period 4 CLK; slave answers miso.
  task automatic xfer(input bit is_b, input logic [7:0] mosi,
                      input logic [7:0] miso);
    logic [7:0] rx;
    bit other_bad;
    rx = 8'h00;
    other_bad = 0;
    slv_exp_q.push_back(mosi);
    for (int i = 7; i >= 0; i--) begin
      set_mosi(is_b, mosi[i]);
      bus.SPI_MISO_IN = miso[i];
      tick(4);
      if ((is_b ? bus.A_SPI_MISO_OUT : bus.B_SPI_MISO_OUT) !== 1'b0)
        other_bad = 1;
      set_sck(is_b, 1'b1);
      #1;
      rx = {rx[6:0], (is_b ? bus.B_SPI_MISO_OUT : bus.A_SPI_MISO_OUT)};
      tick(4);
      set_sck(is_b, 1'b0);
    end
    set_mosi(is_b, 1'b0);
    bus.SPI_MISO_IN = 1'b0;
    checks++;
    if (rx !== miso) begin
      errors++;
      $display("FAIL master_rx(%0d): got %02h, want %02h", is_b, rx, miso);
    end
    checks++;
    if (other_bad) begin
      errors++;
      $display("FAIL other_miso(%0d): got nonzero, want 0", is_b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic check_idle(input string nm);
    bit ok;
    wait_idle(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: BUSY=%b, want 0", nm, bus.BUSY);
    end
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    bus.A_SPI_CLK_IN = 1'b0;
    bus.A_SPI_MOSI_IN = 1'b0;
    bus.A_SPI_NSS_IN = 1'b1;
    bus.B_SPI_CLK_IN = 1'b0;
    bus.B_SPI_MOSI_IN = 1'b0;
    bus.B_SPI_NSS_IN = 1'b1;
    bus.SPI_MISO_IN = 1'b1;
    rst = 1'b1;
    tick(3);
    obs = {bus.SPI_NSS_OUT, bus.SPI_CLK_OUT, bus.SPI_MOSI_OUT,
           bus.A_SPI_MISO_OUT, bus.B_SPI_MISO_OUT,
           bus.A_GNT, bus.B_GNT, bus.BUSY, bus.TIMEOUT_FLAG};
    checks++;
    if (obs !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_outs: got %b, want 100000000", obs);
    end
    rst = 1'b0;
    tick(3);
    obs = {bus.SPI_NSS_OUT, bus.SPI_CLK_OUT, bus.SPI_MOSI_OUT,
           bus.A_SPI_MISO_OUT, bus.B_SPI_MISO_OUT,
           bus.A_GNT, bus.B_GNT, bus.BUSY, bus.TIMEOUT_FLAG};
    checks++;
    if (obs !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL idle_outs: got %b, want 100000000", obs);
    end
    bus.SPI_MISO_IN = 1'b0;
  endtask

  task automatic test_single_a();
    int cyc;
    bit got;
    set_nss(0, 1'b0);
    wait_gnt(0, 10, cyc, got);
    checks++;
    if (!got || cyc > 3) begin
      errors++;
      $display("FAIL a_latency: got %0d cycles (gnt=%b), want <=3",
               cyc, got);
    end
    checks++;
    if ({bus.B_GNT, bus.BUSY, bus.SPI_NSS_OUT} !== 3'b010) begin
      errors++;
      $display("FAIL a_owner: got B_GNT,BUSY,NSS=%b, want 010",
               {bus.B_GNT, bus.BUSY, bus.SPI_NSS_OUT});
    end
    xfer(0, 8'hA5, 8'h3C);
    set_nss(0, 1'b1);
    check_idle("a_release");
  endtask

  task automatic test_simultaneous();
    int cyc;
    int gcnt;
    bit got;
    bit nss_bad;
    do_reset();
    set_nss(0, 1'b0);
    set_nss(1, 1'b0);
    wait_gnt(0, 10, cyc, got);
    checks++;
    if (!got || bus.B_GNT !== 1'b0) begin
      errors++;
      $display("FAIL tie_first: got A_GNT=%b B_GNT=%b, want 1 0",
               bus.A_GNT, bus.B_GNT);
    end
    xfer(0, 8'h5A, 8'hC3);
    set_nss(0, 1'b1);
    gcnt = 0;
    got = 0;
    nss_bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.B_GNT === 1'b1) begin
        got = 1;
        break;
      end
      if (bus.BUSY && !bus.A_GNT) begin
        gcnt++;
        if (bus.SPI_NSS_OUT !== 1'b1) nss_bad = 1;
      end
    end
    checks++;
    if (!got || gcnt != 4) begin
      errors++;
      $display("FAIL guard_len: got %0d cycles (B_GNT=%b), want 4 then 1",
               gcnt, got);
    end
    checks++;
    if (nss_bad) begin
      errors++;
      $display("FAIL guard_nss: got low NSS in guard, want high");
    end
    xfer(1, 8'h96, 8'h69);
    set_nss(1, 1'b1);
    check_idle("b_release");
  endtask

  task automatic test_contention();
    int cyc;
    bit got;
    bit leak;
    set_nss(0, 1'b0);
    wait_gnt(0, 10, cyc, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL cont_a_gnt: got A_GNT=0, want 1");
    end
    set_nss(1, 1'b0);
    set_mosi(1, 1'b1);
    leak = 0;
    for (int i = 0; i < 6; i++) begin
      set_sck(1, 1'b1);
      #1;
      if (bus.SPI_CLK_OUT !== 1'b0 || bus.B_GNT !== 1'b0) leak = 1;
      tick(1);
      set_sck(1, 1'b0);
      tick(1);
    end
    set_mosi(1, 1'b0);
    checks++;
    if (leak) begin
      errors++;
      $display("FAIL b_sck_leak: got B edge on slave SCK, want none");
    end
    xfer(0, 8'h81, 8'h7E);
    set_nss(0, 1'b1);
    wait_gnt(1, 20, cyc, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL loser_gnt: got B_GNT=0, want 1");
    end
    xfer(1, 8'h3B, 8'hE4);
    set_nss(1, 1'b1);
    check_idle("cont_idle");
    set_nss(0, 1'b0);
    set_nss(1, 1'b0);
    wait_gnt(0, 10, cyc, got);
    checks++;
    if (!got || bus.B_GNT !== 1'b0) begin
      errors++;
      $display("FAIL tie_after_b: got A_GNT=%b B_GNT=%b, want 1 0",
               bus.A_GNT, bus.B_GNT);
    end
    set_nss(0, 1'b1);
    set_nss(1, 1'b1);
    check_idle("tie_idle");
  endtask

  task automatic test_round_robin();
    int cyc;
    bit got;
    set_nss(0, 1'b0);
    wait_gnt(0, 10, cyc, got);
    set_nss(0, 1'b1);
    check_idle("rr_a_idle");
    set_nss(0, 1'b0);
    set_nss(1, 1'b0);
    wait_gnt(1, 10, cyc, got);
    checks++;
    if (!got || bus.A_GNT !== 1'b0) begin
      errors++;
      $display("FAIL tie_after_a: got A_GNT=%b B_GNT=%b, want 0 1",
               bus.A_GNT, bus.B_GNT);
    end
    set_nss(0, 1'b1);
    set_nss(1, 1'b1);
    check_idle("rr_idle");
  endtask

  task automatic test_reset_mid_grant();
    int cyc;
    bit got;
    set_nss(1, 1'b0);
    wait_gnt(1, 10, cyc, got);
    checks++;
    if (!got || bus.SPI_NSS_OUT !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: got B_GNT=%b NSS=%b, want 1 0",
               bus.B_GNT, bus.SPI_NSS_OUT);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if ({bus.SPI_NSS_OUT, bus.B_GNT, bus.BUSY} !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset: got NSS,B_GNT,BUSY=%b, want 100",
               {bus.SPI_NSS_OUT, bus.B_GNT, bus.BUSY});
    end
    set_nss(1, 1'b1);
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    int n;
    bit got;
    bit a_bad;
    set_nss(0, 1'b0);
    wait_gnt(0, 10, cyc, got);
    n = 0;
    while (bus.A_GNT === 1'b1 && n < 300) begin
      n++;
      tick(1);
    end
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL to_len: got %0d grant cycles, want 100", n);
    end
    checks++;
    if (bus.TIMEOUT_FLAG !== 1'b1) begin
      errors++;
      $display("FAIL to_flag: got %b, want 1", bus.TIMEOUT_FLAG);
    end
    set_nss(1, 1'b0);
    wait_gnt(1, 20, cyc, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL to_b_gnt: got B_GNT=0, want 1");
    end
    set_nss(1, 1'b1);
    a_bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.A_GNT !== 1'b0) a_bad = 1;
    end
    checks++;
    if (a_bad) begin
      errors++;
      $display("FAIL to_lockout: got A_GNT=1, want 0");
    end
    set_nss(0, 1'b1);
    tick(4);
    set_nss(0, 1'b0);
    wait_gnt(0, 10, cyc, got);
    checks++;
    if (!got || bus.TIMEOUT_FLAG !== 1'b1) begin
      errors++;
      $display("FAIL to_regrant: got A_GNT=%b FLAG=%b, want 1 1",
               got, bus.TIMEOUT_FLAG);
    end
    set_nss(0, 1'b1);
    check_idle("to_idle");
  endtask
`else
  task automatic test_timeout();
    int cyc;
    int n;
    bit got;
    set_nss(0, 1'b0);
    wait_gnt(0, 10, cyc, got);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.A_GNT === 1'b1) n++;
      tick(1);
    end
    checks++;
    if (n != 200) begin
      errors++;
      $display("FAIL long_grant: got %0d cycles, want 200", n);
    end
    checks++;
    if (bus.TIMEOUT_FLAG !== 1'b0) begin
      errors++;
      $display("FAIL no_to_flag: got %b, want 0", bus.TIMEOUT_FLAG);
    end
    set_nss(0, 1'b1);
    check_idle("long_idle");
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    test_simultaneous();
    test_contention();
    test_round_robin();
    test_reset_mid_grant();
    test_timeout();
    checks++;
    if (slv_exp_q.size() != 0) begin
      errors++;
      $display("FAIL slave_q: got %0d bytes outstanding, want 0",
               slv_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
